// File: rtl/switch_merge.sv
// 2:1 merge stage: per-channel FIFOs, round-robin arbitration onto one registered output stream.
// Optional per-channel delivery counters when SWITCH_MERGE_STATS_EN is defined.
module switch_merge #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_vld_a,
  input  logic [ADDR_WIDTH-1:0] i_addr_a,
  input  logic [DATA_WIDTH-1:0] i_data_a,
  output logic                  o_rdy_a,
  input  logic                  i_vld_b,
  input  logic [ADDR_WIDTH-1:0] i_addr_b,
  input  logic [DATA_WIDTH-1:0] i_data_b,
  output logic                  o_rdy_b,
  output logic                  o_vld,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_src,
`ifdef SWITCH_MERGE_STATS_EN
  output logic [15:0]           o_cnt_a,
  output logic [15:0]           o_cnt_b,
`endif
  input  logic                  i_rdy
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned EW = ADDR_WIDTH + DATA_WIDTH;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef logic [EW-1:0] entry_t;

  // Index 0 is channel A, index 1 is channel B.
  entry_t        r_mem  [2][DEPTH];
  logic [PW-1:0] r_wptr [2];
  logic [PW-1:0] r_rptr [2];
  logic [CW-1:0] r_cnt  [2];
  entry_t        w_din  [2];

  logic [1:0] w_vld_in;
  logic [1:0] w_rdy_in;
  logic [1:0] w_push;
  logic [1:0] w_ne;
  logic [1:0] w_pop;
  logic       w_load;
  logic       w_sel_b;

  logic       r_vld;
  logic       r_src;
  logic       r_last;
  entry_t     r_out;

  assign w_vld_in = {i_vld_b, i_vld_a};
  assign w_din[0] = {i_addr_a, i_data_a};
  assign w_din[1] = {i_addr_b, i_data_b};

  // Ready depends on registered occupancy only, so a full FIFO never accepts on its pop cycle.
  assign w_rdy_in[0] = !i_rst && (r_cnt[0] != FULL);
  assign w_rdy_in[1] = !i_rst && (r_cnt[1] != FULL);
  assign w_push      = w_vld_in & w_rdy_in;
  assign w_ne[0]     = (r_cnt[0] != '0);
  assign w_ne[1]     = (r_cnt[1] != '0);

  assign w_load   = !r_vld || i_rdy;
  // r_last: 0 = A granted last, 1 = B granted last.
  assign w_sel_b  = w_ne[1] && (!w_ne[0] || !r_last);
  assign w_pop[0] = w_load && w_ne[0] && !w_sel_b;
  assign w_pop[1] = w_load && w_sel_b;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < 2; i++) begin
        r_wptr[i] <= '0;
        r_rptr[i] <= '0;
        r_cnt[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (w_push[i]) r_wptr[i] <= r_wptr[i] + PW'(1);
        if (w_pop[i])  r_rptr[i] <= r_rptr[i] + PW'(1);
        r_cnt[i] <= r_cnt[i] + CW'(w_push[i]) - CW'(w_pop[i]);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    for (int i = 0; i < 2; i++) begin
      if (w_push[i]) r_mem[i][r_wptr[i]] <= w_din[i];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_vld  <= 1'b0;
      r_src  <= 1'b0;
      r_last <= 1'b1;
      r_out  <= '0;
    end else if (w_load) begin
      if (|w_ne) begin
        r_vld  <= 1'b1;
        r_out  <= w_sel_b ? r_mem[1][r_rptr[1]] : r_mem[0][r_rptr[0]];
        r_src  <= w_sel_b;
        r_last <= w_sel_b;
      end else begin
        r_vld <= 1'b0;
      end
    end
  end

  assign o_rdy_a = w_rdy_in[0];
  assign o_rdy_b = w_rdy_in[1];
  assign o_vld   = r_vld;
  assign o_src   = r_src;
  assign o_addr  = r_out[EW-1:DATA_WIDTH];
  assign o_data  = r_out[DATA_WIDTH-1:0];

`ifdef SWITCH_MERGE_STATS_EN
  logic [15:0] r_stat_a;
  logic [15:0] r_stat_b;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_stat_a <= '0;
      r_stat_b <= '0;
    end else if (r_vld && i_rdy) begin
      if (!r_src && (r_stat_a != 16'hFFFF)) r_stat_a <= r_stat_a + 16'd1;
      if (r_src && (r_stat_b != 16'hFFFF))  r_stat_b <= r_stat_b + 16'd1;
    end
  end

  assign o_cnt_a = r_stat_a;
  assign o_cnt_b = r_stat_b;
`endif

endmodule

// File: tb/tb_switch_merge.sv
// Directed bench for switch_merge: per-channel scoreboard queues checked at every delivery.
module tb_switch_merge;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_vld_a, i_vld_b, i_rdy;
  logic [7:0]  i_addr_a, i_addr_b;
  logic [15:0] i_data_a, i_data_b;
  logic        o_rdy_a, o_rdy_b, o_vld, o_src;
  logic [7:0]  o_addr;
  logic [15:0] o_data;
`ifdef SWITCH_MERGE_STATS_EN
  logic [15:0] o_cnt_a, o_cnt_b;
`endif

  int n_vec = 0;
  int n_bad = 0;
  int n_deliv = 0;
  int n0;
  logic [23:0] q_a[$];
  logic [23:0] q_b[$];
  logic        src_log[$];

  switch_merge #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .DEPTH(4)) dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_vld_a  (i_vld_a),
    .i_addr_a (i_addr_a),
    .i_data_a (i_data_a),
    .o_rdy_a  (o_rdy_a),
    .i_vld_b  (i_vld_b),
    .i_addr_b (i_addr_b),
    .i_data_b (i_data_b),
    .o_rdy_b  (o_rdy_b),
    .o_vld    (o_vld),
    .o_addr   (o_addr),
    .o_data   (o_data),
    .o_src    (o_src),
`ifdef SWITCH_MERGE_STATS_EN
    .o_cnt_a  (o_cnt_a),
    .o_cnt_b  (o_cnt_b),
`endif
    .i_rdy    (i_rdy)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: record accepted packets, compare each delivered beat against its channel queue.
  always @(negedge i_clk) begin
    logic [31:0] exp;
    if (i_rst) begin
      q_a.delete();
      q_b.delete();
    end else begin
      if (i_vld_a && o_rdy_a) q_a.push_back({i_addr_a, i_data_a});
      if (i_vld_b && o_rdy_b) q_b.push_back({i_addr_b, i_data_b});
      if (o_vld && i_rdy) begin
        n_deliv++;
        src_log.push_back(o_src);
        if (o_src == 1'b0) exp = (q_a.size() > 0) ? {8'h0, q_a.pop_front()} : 'x;
        else               exp = (q_b.size() > 0) ? {8'h0, q_b.pop_front()} : 'x;
        check(o_src ? "deliver_b" : "deliver_a", {8'h0, o_addr, o_data}, exp);
      end
    end
  end

  // Offers na packets on A and nb on B, holding each until accepted. Starts and ends at posedge+1.
  task automatic stream(input int na, input int nb, input logic [7:0] abase,
                        input logic [15:0] dbase);
    int ia = 0;
    int ib = 0;
    int guard = 0;
    while ((ia < na || ib < nb) && guard < 200) begin
      i_vld_a  = (ia < na);
      i_addr_a = 8'(abase + ia);
      i_data_a = 16'(dbase + ia);
      i_vld_b  = (ib < nb);
      i_addr_b = 8'(abase + 8'h80 + ib);
      i_data_b = 16'(dbase + 16'h8000 + ib);
      @(negedge i_clk);
      if (i_vld_a && o_rdy_a) ia++;
      if (i_vld_b && o_rdy_b) ib++;
      @(posedge i_clk);
      #1;
      guard++;
    end
    i_vld_a = 1'b0;
    i_vld_b = 1'b0;
    check("stream_accepted", 32'(guard < 200), 32'd1);
  endtask

  task automatic reset_dut();
    i_rst = 1'b1;
    @(posedge i_clk);
    #1;
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
  endtask

  initial begin
    i_rst = 1'b1; i_rdy = 1'b1;
    i_vld_a = 1'b0; i_addr_a = '0; i_data_a = '0;
    i_vld_b = 1'b0; i_addr_b = '0; i_data_b = '0;

    // Reset for two cycles
    @(posedge i_clk);
    @(negedge i_clk);
    check("rst_vld", 32'(o_vld), 32'd0);
    check("rst_addr", 32'(o_addr), 32'd0);
    check("rst_data", 32'(o_data), 32'd0);
    check("rst_src", 32'(o_src), 32'd0);
    check("rst_rdy_a", 32'(o_rdy_a), 32'd0);
    check("rst_rdy_b", 32'(o_rdy_b), 32'd0);
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    @(negedge i_clk);
    check("post_rst_rdy_a", 32'(o_rdy_a), 32'd1);
    check("post_rst_rdy_b", 32'(o_rdy_b), 32'd1);
    @(posedge i_clk);
    #1;

    // Single packet on A: two-edge latency, single beat
    stream(1, 0, 8'h11, 16'h1234);
    @(negedge i_clk);
    check("lat_vld_early", 32'(o_vld), 32'd0);
    @(negedge i_clk);
    check("lat_vld", 32'(o_vld), 32'd1);
    check("lat_addr", 32'(o_addr), 32'h11);
    check("lat_data", 32'(o_data), 32'h1234);
    check("lat_src", 32'(o_src), 32'd0);
    @(negedge i_clk);
    check("single_beat", 32'(o_vld), 32'd0);
    @(posedge i_clk);
    #1;

    // Both channels contend from reset: strict A/B alternation
    reset_dut();
    src_log.delete();
    stream(4, 4, 8'h20, 16'h2000);
    repeat (12) @(posedge i_clk);
    #1;
    check("rr_count", 32'(src_log.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      check("rr_src", (i < src_log.size()) ? 32'(src_log[i]) : 'x, 32'(i % 2));
    end
    check("rr_q_a_empty", 32'(q_a.size()), 32'd0);
    check("rr_q_b_empty", 32'(q_b.size()), 32'd0);

    // Backpressure: fill B while output stalled, verify hold, then drain
    i_rdy = 1'b0;
    n0 = n_deliv;
    stream(0, 5, 8'h40, 16'h4000);
    @(negedge i_clk);
    check("bp_rdy_b", 32'(o_rdy_b), 32'd0);
    check("bp_vld", 32'(o_vld), 32'd1);
    check("bp_addr", 32'(o_addr), 32'hC0);
    check("bp_data", 32'(o_data), 32'hC000);
    i_vld_b = 1'b1; i_addr_b = 8'hEE; i_data_b = 16'hEEEE;
    repeat (3) begin
      @(negedge i_clk);
      check("bp_hold_rdy_b", 32'(o_rdy_b), 32'd0);
      check("bp_hold_vld", 32'(o_vld), 32'd1);
      check("bp_hold_out", {8'h0, o_addr, o_data}, 32'hC0C000);
    end
    @(posedge i_clk);
    #1;
    i_vld_b = 1'b0;
    i_rdy = 1'b1;
    repeat (10) @(posedge i_clk);
    #1;
    check("bp_drained", 32'(n_deliv - n0), 32'd5);
    check("bp_q_b_empty", 32'(q_b.size()), 32'd0);

    // Reset mid-drain discards buffered and pending packets
    i_rdy = 1'b0;
    stream(0, 4, 8'h50, 16'h5000);
    n0 = n_deliv;
    i_rst = 1'b1;
    @(negedge i_clk);
    check("mid_rst_rdy_a", 32'(o_rdy_a), 32'd0);
    check("mid_rst_rdy_b", 32'(o_rdy_b), 32'd0);
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    @(negedge i_clk);
    check("mid_rst_vld", 32'(o_vld), 32'd0);
    check("mid_rst_rdy_b_up", 32'(o_rdy_b), 32'd1);
    i_rdy = 1'b1;
    repeat (10) @(posedge i_clk);
    @(negedge i_clk);
    check("no_stale_deliv", 32'(n_deliv - n0), 32'd0);
    check("no_stale_vld", 32'(o_vld), 32'd0);
    @(posedge i_clk);
    #1;

`ifdef SWITCH_MERGE_STATS_EN
    reset_dut();
    stream(3, 2, 8'h60, 16'h6000);
    repeat (10) @(posedge i_clk);
    #1;
    check("stat_cnt_a", 32'(o_cnt_a), 32'd3);
    check("stat_cnt_b", 32'(o_cnt_b), 32'd2);
    force dut.r_stat_a = 16'hFFFF;
    @(posedge i_clk);
    #1;
    release dut.r_stat_a;
    stream(1, 0, 8'h70, 16'h7000);
    repeat (6) @(posedge i_clk);
    #1;
    check("stat_sat_a", 32'(o_cnt_a), 32'hFFFF);
    check("stat_sat_b", 32'(o_cnt_b), 32'd2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
